piece_move_engine: RTL

- Parametrised successor to the fixed 12x20 grid controller.
- Owns the active tetromino as four (row, col) cells and executes LEFT/RIGHT/DOWN/HARD_DROP commands plus internal gravity ticks against a row-major grid RAM.
- Collision uses row/col arithmetic rather than hard-coded border addresses.
- Sits between the input controller / piece spawner and the grid-memory mux. Reports landing so the line clearer can run.

---
 rtl/tetris_pkg.sv | 34 +++
 rtl/gravity_timer.sv | 29 ++
 rtl/piece_move_engine.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared command codes, block codes, FSM states and cell type
package tetris_pkg;

    localparam logic [1:0] CMD_LEFT  = 2'b00;
    localparam logic [1:0] CMD_RIGHT = 2'b01;
    localparam logic [1:0] CMD_DOWN  = 2'b10;
    localparam logic [1:0] CMD_DROP  = 2'b11;

    localparam logic [3:0] BLOCK_AIR    = 4'd0;
    localparam logic [3:0] BLOCK_I      = 4'd1;
    localparam logic [3:0] BLOCK_O      = 4'd2;
    localparam logic [3:0] BLOCK_T      = 4'd3;
    localparam logic [3:0] BLOCK_S      = 4'd4;
    localparam logic [3:0] BLOCK_Z      = 4'd5;
    localparam logic [3:0] BLOCK_J      = 4'd6;
    localparam logic [3:0] BLOCK_L      = 4'd7;
    localparam logic [3:0] BLOCK_BORDER = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_RD_ADDR,
        ST_RD_CHK,
        ST_ERASE,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
    } cell_t;

endpackage

// File: rtl/gravity_timer.sv
// rtl/gravity_timer.sv - gravity step counter with a sticky tick_pending flag
module gravity_timer #(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick_pending
);
    localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    // The flag holds until the engine consumes the tick; counting pauses meanwhile.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count        <= '0;
            tick_pending <= 1'b0;
        end else if (enable && !tick_pending) begin
            if (count == CNT_W'(TICK_CYCLES - 1)) begin
                tick_pending <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/piece_move_engine.sv
// rtl/piece_move_engine.sv - moves the active tetromino against a row-major grid RAM
module piece_move_engine
    import tetris_pkg::*;
#(
    parameter int COLS        = 10,
    parameter int ROWS        = 20,
    parameter int DATA_W      = 8,
    parameter int TICK_CYCLES = 50000000,
    parameter int ADDR_W      = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [63:0]       load_cells,
    input  logic [DATA_W-1:0] load_type,
    output logic              load_ready,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    output logic              cmd_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              piece_active,
    output logic              done,
    output logic              moved,
    output logic              landed
);
    localparam logic signed [8:0] COLS_S = 9'(COLS);
    localparam logic signed [8:0] ROWS_S = 9'(ROWS);

    state_t            state, state_next;
    cell_t             cells [4];
    cell_t             nxt   [4];
    logic [DATA_W-1:0] piece_type;
    logic [1:0]        idx;
    logic [1:0]        op;
    logic              loading, moved_r, landed_r;
    logic              tick_pending, tick_go, cmd_go, restart;
    logic signed [8:0] calc_row [4];
    logic signed [8:0] calc_col [4];
    logic              out_of_bounds, self_hit, occupied, vertical;
    logic              unused_rdata_bits;

    function automatic logic [ADDR_W-1:0] addr_of(input cell_t c);
        return ADDR_W'(32'(c.row) * COLS + 32'(c.col));
    endfunction

    assign unused_rdata_bits = ^mem_rdata[DATA_W-1:4];

    gravity_timer #(.TICK_CYCLES(TICK_CYCLES)) u_gravity_timer (
        .clk          (clk),
        .reset        (reset),
        .enable       (piece_active),
        .restart      (restart),
        .tick_pending (tick_pending)
    );

    assign load_ready = (state == ST_IDLE);
    assign cmd_ready  = (state == ST_IDLE) && piece_active && !tick_pending;
    assign tick_go    = (state == ST_IDLE) && !load_valid && piece_active && tick_pending;
    assign cmd_go     = !load_valid && cmd_valid && cmd_ready;
    assign restart    = (state == ST_IDLE) && (load_valid || tick_go);
    assign vertical   = (op == CMD_DOWN) || (op == CMD_DROP);
    assign done       = (state == ST_DONE);
    assign moved      = done && moved_r;
    assign landed     = done && landed_r;

    // Signed 9-bit arithmetic so that col 0 minus one is seen as negative.
    always_comb begin
        out_of_bounds = 1'b0;
        for (int i = 0; i < 4; i++) begin
            calc_row[i] = $signed({1'b0, cells[i].row});
            calc_col[i] = $signed({1'b0, cells[i].col});
            case (op)
                CMD_LEFT:  calc_col[i] = calc_col[i] - 9'sd1;
                CMD_RIGHT: calc_col[i] = calc_col[i] + 9'sd1;
                default:   calc_row[i] = calc_row[i] + 9'sd1;
            endcase
            if (calc_col[i] < 9'sd0 || calc_col[i] >= COLS_S || calc_row[i] >= ROWS_S) begin
                out_of_bounds = 1'b1;
            end
        end
    end

    // A target cell still held by the piece itself is vacated by the move.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (nxt[idx] == cells[i]) self_hit = 1'b1;
        end
        occupied = (mem_rdata[3:0] != BLOCK_AIR) && !self_hit;
    end

    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_valid)           state_next = ST_WRITE;
                else if (tick_go || cmd_go) state_next = ST_CALC;
            end
            ST_CALC:    state_next = out_of_bounds ? ST_DONE : ST_RD_ADDR;
            ST_RD_ADDR: begin
                mem_addr   = addr_of(nxt[idx]);
                state_next = ST_RD_CHK;
            end
            ST_RD_CHK: begin
                mem_addr = addr_of(nxt[idx]);
                if (occupied)         state_next = ST_DONE;
                else if (idx == 2'd3) state_next = ST_ERASE;
                else                  state_next = ST_RD_ADDR;
            end
            ST_ERASE: begin
                mem_addr = addr_of(cells[idx]);
                mem_we   = 1'b1;
                if (idx == 2'd3) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem_addr  = addr_of(nxt[idx]);
                mem_wdata = piece_type;
                mem_we    = 1'b1;
                if (idx == 2'd3) begin
                    state_next = (op == CMD_DROP && !loading) ? ST_CALC : ST_DONE;
                end
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cells        <= '{default: '0};
            nxt          <= '{default: '0};
            piece_type   <= '0;
            idx          <= '0;
            op           <= CMD_LEFT;
            loading      <= 1'b0;
            moved_r      <= 1'b0;
            landed_r     <= 1'b0;
            piece_active <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    idx      <= '0;
                    moved_r  <= 1'b0;
                    landed_r <= 1'b0;
                    if (load_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            cells[i] <= cell_t'(load_cells[16*i +: 16]);
                            nxt[i]   <= cell_t'(load_cells[16*i +: 16]);
                        end
                        piece_type <= load_type;
                        loading    <= 1'b1;
                    end else if (tick_go) begin
                        op      <= CMD_DOWN;
                        loading <= 1'b0;
                    end else if (cmd_go) begin
                        op      <= cmd;
                        loading <= 1'b0;
                    end
                end
                ST_CALC: begin
                    idx <= '0;
                    for (int i = 0; i < 4; i++) begin
                        nxt[i] <= cell_t'({calc_row[i][7:0], calc_col[i][7:0]});
                    end
                    if (out_of_bounds && vertical) begin
                        landed_r     <= 1'b1;
                        piece_active <= 1'b0;
                    end
                end
                ST_RD_CHK: begin
                    if (occupied) begin
                        if (vertical) begin
                            landed_r     <= 1'b1;
                            piece_active <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                ST_ERASE: idx <= idx + 2'd1;
                ST_WRITE: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        cells <= nxt;
                        if (loading) piece_active <= 1'b1;
                        else         moved_r      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
